// File: rtl/seg7_sequence_checker.sv
// seg7_sequence_checker
// Decodes an active-low 7-segment glyph stream back to 3-bit values, tracks it
// against a modulo-(MAX_VAL+1) count, locks onto it and flags/counts breaks.
// Optional: define SEG_BLANK_HOLD_EN to treat the all-off pattern as a
// blank/hold glyph that is ignored entirely.
//
// state  | meaning
// HUNT   | no reference value yet, waiting for any legal glyph
// SYNC   | counting consecutive correct increments toward lock
// LOCKED | stream follows the count; any break is an error event
// FAULT  | lock lost, waiting for a legal glyph to resynchronise
module seg7_sequence_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int MAX_VAL    = 7,
  parameter int ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             iSample,
  input  logic [6:0]       iDisplay,
  input  logic             iClrErr,
  output logic [2:0]       oQ,
  output logic             oValid,
  output logic             oLegal,
  output logic             oLocked,
  output logic             oErr,
  output logic [ERR_W-1:0] oErrCount
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED, FAULT} state_t;

  localparam logic [2:0] MAX_Q  = 3'(MAX_VAL);
  localparam logic [3:0] LOCK_Q = 4'(LOCK_COUNT);

  state_t     state;
  logic [3:0] match;
  logic [2:0] prev;

  logic [2:0] dec_val;
  logic       dec_hit;
  logic       legal;
  logic       blank;
  logic       accept;
  logic [2:0] expected;
  logic       in_seq;
  logic [3:0] match_inc;
  logic       err_ev;

  // glyph decode, qualification and the error-event condition
  always_comb begin
    dec_val = 3'd0;
    dec_hit = 1'b1;
    case (iDisplay)
      7'b1000000: dec_val = 3'd0;
      7'b1111001: dec_val = 3'd1;
      7'b0100100: dec_val = 3'd2;
      7'b0110000: dec_val = 3'd3;
      7'b0011001: dec_val = 3'd4;
      7'b0010010: dec_val = 3'd5;
      7'b0000010: dec_val = 3'd6;
      7'b1111000: dec_val = 3'd7;
      default:    dec_hit = 1'b0;
    endcase
    legal = dec_hit && (dec_val <= MAX_Q);
`ifdef SEG_BLANK_HOLD_EN
    blank = (iDisplay == 7'b1111111);
`else
    blank = 1'b0;
`endif
    accept    = iSample && !blank;
    expected  = (prev == MAX_Q) ? 3'd0 : prev + 3'd1;
    in_seq    = legal && (dec_val == expected);
    match_inc = match + 4'd1;
    err_ev    = accept && (state == LOCKED) && !in_seq;
  end

  // sequence-tracking FSM with registered decode outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= HUNT;
      match   <= 4'd0;
      prev    <= 3'd0;
      oQ      <= 3'd0;
      oValid  <= 1'b0;
      oLegal  <= 1'b0;
      oLocked <= 1'b0;
    end else begin
      oValid <= accept;
      if (accept) begin
        oLegal <= legal;
        if (legal) begin
          oQ   <= dec_val;
          prev <= dec_val;
        end
        case (state)
          HUNT: begin
            if (legal) begin
              state <= SYNC;
              match <= 4'd0;
            end
          end
          SYNC: begin
            if (!legal) begin
              state <= HUNT;
            end else if (in_seq) begin
              match <= match_inc;
              if (match_inc == LOCK_Q) begin
                state   <= LOCKED;
                oLocked <= 1'b1;
              end
            end else begin
              match <= 4'd0;
            end
          end
          LOCKED: begin
            if (!in_seq) begin
              state   <= FAULT;
              oLocked <= 1'b0;
            end
          end
          FAULT: begin
            if (legal) begin
              state <= SYNC;
              match <= 4'd0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // sticky error flag and saturating error counter; an error beats a clear
  always_ff @(posedge CLK) begin
    if (rst) begin
      oErr      <= 1'b0;
      oErrCount <= '0;
    end else if (err_ev) begin
      oErr <= 1'b1;
      if (iClrErr)
        oErrCount <= ERR_W'(1);
      else if (oErrCount != {ERR_W{1'b1}})
        oErrCount <= oErrCount + ERR_W'(1);
    end else if (iClrErr) begin
      oErr      <= 1'b0;
      oErrCount <= '0;
    end
  end

endmodule

// File: tb/tb_seg7_sequence_checker.sv
// tb_seg7_sequence_checker
// Directed test-plan scenarios followed by biased random glyph traffic, all
// compared cycle by cycle against a behavioural model of the checker.
module tb_seg7_sequence_checker;

  localparam int LOCK_COUNT = 3;
  localparam int MAX_VAL    = 7;
  localparam int ERR_W      = 8;
  localparam int CNT_MAX    = (1 << ERR_W) - 1;

  logic             CLK;
  logic             rst;
  logic             iSample;
  logic [6:0]       iDisplay;
  logic             iClrErr;
  logic [2:0]       oQ;
  logic             oValid;
  logic             oLegal;
  logic             oLocked;
  logic             oErr;
  logic [ERR_W-1:0] oErrCount;

  seg7_sequence_checker #(
    .LOCK_COUNT(LOCK_COUNT),
    .MAX_VAL   (MAX_VAL),
    .ERR_W     (ERR_W)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .iSample  (iSample),
    .iDisplay (iDisplay),
    .iClrErr  (iClrErr),
    .oQ       (oQ),
    .oValid   (oValid),
    .oLegal   (oLegal),
    .oLocked  (oLocked),
    .oErr     (oErr),
    .oErrCount(oErrCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [6:0] glyph_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  int errors = 0;
  int checks = 0;

  // reference model: mode 0=hunting 1=syncing 2=locked 3=faulted
  int m_mode, m_run, m_prev;
  int m_q, m_valid, m_legal, m_locked, m_err, m_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int glyph_value(input logic [6:0] d);
    int v = -1;
    for (int i = 0; i < 8; i++)
      if (glyph_tab[i] == d) v = i;
    return v;
  endfunction

  task automatic model_step(input bit s, input logic [6:0] d, input bit c, input bit r);
    int v, nxt;
    bit acc, leg, ev;
    if (r) begin
      m_mode = 0; m_run = 0; m_prev = 0;
      m_q = 0; m_valid = 0; m_legal = 0; m_locked = 0; m_err = 0; m_cnt = 0;
      return;
    end
    acc = s;
`ifdef SEG_BLANK_HOLD_EN
    if (d == 7'b1111111) acc = 0;
`endif
    v   = glyph_value(d);
    leg = (v >= 0) && (v <= MAX_VAL);
    nxt = (m_prev + 1) % (MAX_VAL + 1);
    ev  = 0;
    m_valid = acc;
    if (acc) begin
      m_legal = leg;
      if (leg) m_q = v;
      if (m_mode == 0) begin
        if (leg) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        if (!leg) m_mode = 0;
        else if (v == nxt) begin
          m_run++;
          if (m_run >= LOCK_COUNT) m_mode = 2;
        end else m_run = 0;
      end else if (m_mode == 2) begin
        if (!(leg && v == nxt)) begin m_mode = 3; ev = 1; end
      end else begin
        if (leg) begin m_mode = 1; m_run = 0; end
      end
      if (leg) m_prev = v;
    end
    m_locked = (m_mode == 2);
    if (ev) begin
      m_err = 1;
      m_cnt = c ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
    end else if (c) begin
      m_err = 0;
      m_cnt = 0;
    end
  endtask

  task automatic step(input bit s, input logic [6:0] d, input bit c, input bit r);
    iSample  = s;
    iDisplay = d;
    iClrErr  = c;
    rst      = r;
    model_step(s, d, c, r);
    @(posedge CLK);
    #1;
    check("oValid",    int'(oValid),    m_valid);
    check("oLegal",    int'(oLegal),    m_legal);
    check("oLocked",   int'(oLocked),   m_locked);
    check("oErr",      int'(oErr),      m_err);
    check("oErrCount", int'(oErrCount), m_cnt);
    if (m_legal == 1 || m_valid == 1 || r) check("oQ", int'(oQ), m_q);
  endtask

  task automatic samp(input int v);
    step(1, glyph_tab[v], 0, 0);
  endtask

  initial begin
    int r, pick;
    logic [6:0] d;
    iSample = 0; iDisplay = 7'h7F; iClrErr = 0; rst = 1;

    // reset state
    step(0, 7'h7F, 0, 1);
    step(1, glyph_tab[5], 1, 1);
    check("rst_oQ", int'(oQ), 0);
    check("rst_locked", int'(oLocked), 0);

    // initial lock at the third correct increment
    samp(0); samp(1); samp(2);
    check("pre_lock", int'(oLocked), 0);
    samp(3);
    check("lock_q", int'(oQ), 3);
    check("lock_flag", int'(oLocked), 1);

    // wrap-around while locked
    samp(4); samp(5); samp(6); samp(7); samp(0); samp(1);
    check("wrap_locked", int'(oLocked), 1);
    check("wrap_cnt", int'(oErrCount), 0);

    // break while locked, then relock
    samp(2); samp(5);
    check("brk_locked", int'(oLocked), 0);
    check("brk_cnt", int'(oErrCount), 1);
    samp(6); samp(7); samp(0); samp(1);
    check("relock_q", int'(oQ), 1);
    check("relock", int'(oLocked), 1);

    // illegal glyph while locked, again while faulted, then clear vs error
    step(1, 7'b1111110, 0, 0);
    check("ill_legal", int'(oLegal), 0);
    check("ill_q", int'(oQ), 1);
    check("ill_cnt", int'(oErrCount), 2);
    step(1, 7'b0000000, 0, 0);
    check("ill2_cnt", int'(oErrCount), 2);
    samp(2); samp(3); samp(4); samp(5);
    step(1, glyph_tab[5], 1, 0);
    check("clr_err", int'(oErr), 1);
    check("clr_cnt", int'(oErrCount), 1);
    step(0, 7'h7F, 1, 0);
    check("clr_only", int'(oErrCount), 0);

    // saturate the error counter with repeated lock/stall cycles
    for (int k = 0; k < CNT_MAX + 5; k++) begin
      samp(0); samp(1); samp(2); samp(3); samp(3);
    end
    check("sat_cnt", int'(oErrCount), CNT_MAX);
    samp(0); samp(1);
    step(1, glyph_tab[2], 0, 1);
    check("mid_rst_cnt", int'(oErrCount), 0);
    check("mid_rst_valid", int'(oValid), 0);

    // blank glyph between 3 and 4 while locked
    samp(0); samp(1); samp(2); samp(3);
    step(1, 7'b1111111, 0, 0);
`ifdef SEG_BLANK_HOLD_EN
    check("blank_valid", int'(oValid), 0);
    check("blank_locked", int'(oLocked), 1);
`else
    check("blank_cnt", int'(oErrCount), 1);
    check("blank_locked", int'(oLocked), 0);
`endif
    samp(4);

    // biased random traffic
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      d = glyph_tab[(m_prev + 1) % (MAX_VAL + 1)];
      else if (r < 80) d = glyph_tab[$urandom_range(0, 7)];
      else if (r < 90) d = 7'($urandom_range(0, 127));
      else if (r < 95) d = 7'b1111111;
      else             d = glyph_tab[m_prev];
      pick = $urandom_range(0, 9);
      step(pick != 0, d, $urandom_range(0, 49) == 0, $urandom_range(0, 499) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
